adc_trig_capture: RTL and testbench

//  Parametrised triggered capture buffer for the ADC waveform path: stores NCH channels of decimated
//  ADC samples into a circular RAM with pre-trigger history, then freezes for the LCD waveform renderer.

---
 rtl/adc_trig_capture.sv | 228 ++++++++++++++++++++++
 tb/tb_adc_trig_capture.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_trig_capture.sv
// adc_trig_capture: triggered multi-channel capture buffer with pre-trigger history.
// Strobe-qualified ADC sample sets are decimated and written into a circular RAM.
// Triggers are edge (rising/falling/either), auto or software force. After the
// post-trigger count is reached the buffer freezes for readout in logical order.
// Optional build macro: ADC_CAP_PEAK_EN -- each stored channel value is the max
// over its decimation window instead of the sample picked at counter==0.
module adc_trig_capture #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NCH      = 2,
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned PRE_TRIG = 128,
  localparam int unsigned ADDR_W  = $clog2(DEPTH),
  localparam int unsigned CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  ad_valid,
  input  logic [NCH*DATA_W-1:0] ad_data,
  input  logic                  arm,
  input  logic                  force_trig,
  input  logic [1:0]            trig_mode,
  input  logic [CH_W-1:0]       trig_ch,
  input  logic [DATA_W-1:0]     trig_level,
  input  logic [7:0]            decim,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     trig_addr,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [NCH*DATA_W-1:0] rd_data
);

  localparam int unsigned SET_W  = NCH * DATA_W;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned POST_N = DEPTH - PRE_TRIG;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_AUTO = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic [ADDR_W-1:0]   r_trig_addr;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [7:0]          r_dec_cnt;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_prev;
  logic                r_prev_vld;
  logic                r_force;
  logic [1:0]          r_mode;
  logic [CH_W-1:0]     r_trig_ch;
  logic [DATA_W-1:0]   r_level;
  logic [7:0]          r_decim;
  logic [SET_W-1:0]    r_rd_data;
  logic [SET_W-1:0]    r_ram [DEPTH];

  logic                w_active;
  logic                w_store;
  logic [SET_W-1:0]    w_sample;
  logic [DATA_W-1:0]   w_cur;
  logic                w_rise;
  logic                w_fall;
  logic                w_hit;
  logic                w_trig;
  logic [ADDR_W-1:0]   w_rd_phys;

  assign w_active = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
  assign w_store  = ad_valid && !arm && w_active && (r_dec_cnt == 8'd0);

`ifdef ADC_CAP_PEAK_EN
  logic [SET_W-1:0] r_peak;

  // Per-channel running max of the current decimation window
  always_comb begin
    w_sample = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      w_sample[c*DATA_W +: DATA_W] =
        (ad_data[c*DATA_W +: DATA_W] > r_peak[c*DATA_W +: DATA_W]) ?
          ad_data[c*DATA_W +: DATA_W] : r_peak[c*DATA_W +: DATA_W];
    end
  end

  // Window accumulator: cleared on arm and after each store
  always_ff @(posedge sys_clk) begin
    if (sys_rst || arm) begin
      r_peak <= '0;
    end else if (w_active && ad_valid) begin
      r_peak <= w_store ? '0 : w_sample;
    end
  end
`else
  assign w_sample = ad_data;
`endif

  // Trigger channel value of the sample set being stored
  always_comb begin
    w_cur = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (CH_W'(c) == r_trig_ch) begin
        w_cur = w_sample[c*DATA_W +: DATA_W];
      end
    end
  end

  // Edge qualification against the previously stored sample
  always_comb begin
    w_rise = r_prev_vld && (r_prev <  r_level) && (w_cur >= r_level);
    w_fall = r_prev_vld && (r_prev >= r_level) && (w_cur <  r_level);
    w_hit  = 1'b0;
    case (r_mode)
      MODE_RISE: w_hit = w_rise;
      MODE_FALL: w_hit = w_fall;
      MODE_BOTH: w_hit = w_rise || w_fall;
      MODE_AUTO: w_hit = 1'b1;
      default:   w_hit = 1'b0;
    endcase
    w_trig = w_hit || r_force || force_trig;
  end

  // Capture FSM with decimation, pointers and registered status
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_trig_addr <= '0;
      r_wr_ptr    <= '0;
      r_dec_cnt   <= '0;
      r_cnt       <= '0;
      r_prev      <= '0;
      r_prev_vld  <= 1'b0;
      r_force     <= 1'b0;
      r_mode      <= '0;
      r_trig_ch   <= '0;
      r_level     <= '0;
      r_decim     <= '0;
    end else if (arm) begin
      r_mode     <= trig_mode;
      r_trig_ch  <= trig_ch;
      r_level    <= trig_level;
      r_decim    <= decim;
      r_dec_cnt  <= decim;
      r_cnt      <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_force    <= 1'b0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_state    <= (PRE_TRIG == 0) ? S_WAIT : S_PRE;
    end else begin
      if ((r_state == S_WAIT) && force_trig) begin
        r_force <= 1'b1;
      end
      if (w_active && ad_valid) begin
        if (r_dec_cnt == 8'd0) begin
          r_dec_cnt  <= r_decim;
          r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
          r_prev     <= w_cur;
          r_prev_vld <= 1'b1;
          case (r_state)
            S_PRE: begin
              if (r_cnt == CNT_W'(PRE_TRIG - 1)) begin
                r_cnt   <= '0;
                r_state <= S_WAIT;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
            S_WAIT: begin
              if (w_trig) begin
                r_trig_addr <= r_wr_ptr;
                r_force     <= 1'b0;
                if (POST_N == 1) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end else begin
                  r_cnt   <= CNT_W'(1);
                  r_state <= S_POST;
                end
              end
            end
            S_POST: begin
              if (r_cnt == CNT_W'(POST_N - 1)) begin
                r_cnt   <= '0;
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
            default: r_state <= r_state;
          endcase
        end else begin
          r_dec_cnt <= r_dec_cnt - 8'd1;
        end
      end
    end
  end

  // Sample RAM write port
  always_ff @(posedge sys_clk) begin
    if (w_store) begin
      r_ram[r_wr_ptr] <= w_sample;
    end
  end

  // Logical-to-physical readout, one cycle latency
  assign w_rd_phys = r_trig_addr - ADDR_W'(PRE_TRIG) + rd_addr;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_ram[w_rd_phys];
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign trig_addr = r_trig_addr;
  assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_adc_trig_capture.sv
// Self-checking bench for adc_trig_capture (DEPTH=16, PRE_TRIG=4, NCH=2, DATA_W=8).
module tb_adc_trig_capture;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        ad_valid;
  logic [15:0] ad_data;
  logic        arm;
  logic        force_trig;
  logic [1:0]  trig_mode;
  logic [0:0]  trig_ch;
  logic [7:0]  trig_level;
  logic [7:0]  decim;
  logic        busy;
  logic        done;
  logic [3:0]  trig_addr;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int          tag;
    logic [3:0]  addr;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t     vecs[$];
  logic [15:0] sb[$];

  adc_trig_capture #(
    .DATA_W(8), .NCH(2), .DEPTH(16), .PRE_TRIG(4)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ad_valid(ad_valid), .ad_data(ad_data),
    .arm(arm), .force_trig(force_trig), .trig_mode(trig_mode), .trig_ch(trig_ch),
    .trig_level(trig_level), .decim(decim), .busy(busy), .done(done),
    .trig_addr(trig_addr), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic send(input logic [15:0] d);
    ad_data  = d;
    ad_valid = 1'b1;
    tick();
    ad_valid = 1'b0;
    tick();
  endtask

  task automatic do_arm(input logic [1:0] m, input logic ch, input logic [7:0] lvl,
                        input logic [7:0] dc, input logic with_valid);
    trig_mode  = m;
    trig_ch    = ch;
    trig_level = lvl;
    decim      = dc;
    arm        = 1'b1;
    ad_valid   = with_valid;
    ad_data    = 16'hEEEE;
    tick();
    arm        = 1'b0;
    ad_valid   = 1'b0;
  endtask

  // Apply every readout vector of a given test through the scoreboard
  task automatic readout(input int tag, input string name);
    logic [15:0] exp;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].tag == tag) begin
        rd_addr = vecs[i].addr;
        sb.push_back(vecs[i].exp);
        tick();
        exp = sb.pop_front();
        check($sformatf("%s_rd%0d", name, vecs[i].addr), int'(rd_data), int'(exp));
      end
    end
  endtask

  function automatic logic [7:0] ch0_b(input int j);
    return (j % 2 == 1) ? 8'(j) : 8'(8'hF0 + j);
  endfunction

  initial begin
    int          n;
    logic [7:0]  v;
    logic [7:0]  peak_exp;

    // Test A: ramp, expected logical readout (ch1 = ~ch0)
    for (int i = 0; i < 16; i++) begin
      v = 8'((i + 4) * 16);
      vecs.push_back('{0, 4'(i), {~v, v}});
    end
    // Test B: falling trigger on ch1
    vecs.push_back('{1, 4'd0,  {8'hFF, ch0_b(2)}});
    vecs.push_back('{1, 4'd3,  {8'hFF, ch0_b(5)}});
    vecs.push_back('{1, 4'd4,  {8'h10, ch0_b(6)}});
    vecs.push_back('{1, 4'd15, {8'h21, ch0_b(17)}});
    // Test C: decimation by 4, stores picked at valids 3,7,11,...
`ifdef ADC_CAP_PEAK_EN
    peak_exp = 8'hFF;
`else
    peak_exp = 8'h07;
`endif
    vecs.push_back('{2, 4'd0,  {8'h03, 8'h03}});
    vecs.push_back('{2, 4'd1,  {8'h07, peak_exp}});
    vecs.push_back('{2, 4'd2,  {8'h0B, 8'h0B}});
    vecs.push_back('{2, 4'd15, {8'h3F, 8'h3F}});
    // Test D: forced trigger, ch1 carries sample index
    vecs.push_back('{3, 4'd4,  {8'd7, 8'h20}});
    vecs.push_back('{3, 4'd3,  {8'd6, 8'h20}});
    // Test E: restart after arm in POST
    vecs.push_back('{4, 4'd0,  {8'h40, 8'h30}});
    vecs.push_back('{4, 4'd15, {8'h4F, 8'h3F}});

    sys_rst = 1'b1; ad_valid = 1'b0; ad_data = '0; arm = 1'b0; force_trig = 1'b0;
    trig_mode = '0; trig_ch = '0; trig_level = '0; decim = '0; rd_addr = '0;
    tick(); tick(); tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_trig_addr", int'(trig_addr), 0);
    check("rst_rd_data", int'(rd_data), 0);
    sys_rst = 1'b0;
    tick();

    // A: rising trigger at 0x80, wr_ptr starts at 0
    do_arm(2'b00, 1'b0, 8'h80, 8'd0, 1'b0);
    check("A_busy", int'(busy), 1);
    n = 0; v = 8'h00;
    while (!done && n < 40) begin
      send({~v, v});
      v = v + 8'h10;
      n++;
    end
    check("A_samples", n, 20);
    check("A_done", int'(done), 1);
    check("A_busy_end", int'(busy), 0);
    check("A_trig_addr", int'(trig_addr), 8);
    readout(0, "A");

    // B: falling trigger on ch1; ch0 toggles through level and must be ignored
    do_arm(2'b01, 1'b1, 8'h80, 8'd0, 1'b0);
    check("B_done_fall", int'(done), 0);
    n = 0;
    while (!done && n < 40) begin
      if (n < 6)       send({8'hFF, ch0_b(n)});
      else if (n == 6) send({8'h10, ch0_b(n)});
      else             send({8'(8'h10 + n), ch0_b(n)});
      n++;
    end
    check("B_samples", n, 18);
    check("B_trig_addr", int'(trig_addr), 10);
    readout(1, "B");

    // C: decim=3, auto trigger, spike 0xFF on ch0 at valid 5
    do_arm(2'b11, 1'b0, 8'h00, 8'd3, 1'b0);
    n = 0;
    while (!done && n < 100) begin
      v = 8'(n);
      send({v, (n == 5) ? 8'hFF : v});
      n++;
    end
    check("C_valids", n, 64);
    check("C_trig_addr", int'(trig_addr), 10);
    readout(2, "C");

    // D: flat input, force in PRE ignored, force in WAIT triggers next store
    do_arm(2'b00, 1'b0, 8'h80, 8'd0, 1'b0);
    send({8'd0, 8'h20});
    send({8'd1, 8'h20});
    force_trig = 1'b1; tick(); force_trig = 1'b0;
    for (int j = 2; j < 7; j++) send({8'(j), 8'h20});
    check("D_no_early_trig", int'(trig_addr), 10);
    force_trig = 1'b1; tick(); force_trig = 1'b0;
    for (int j = 7; j < 18; j++) send({8'(j), 8'h20});
    check("D_done_pending", int'(done), 0);
    send({8'd18, 8'h20});
    check("D_done", int'(done), 1);
    check("D_trig_addr", int'(trig_addr), 13);
    readout(3, "D");

    // E: arm mid-POST (with a coincident ad_valid) restarts from PRE
    do_arm(2'b11, 1'b0, 8'h00, 8'd0, 1'b0);
    for (int j = 0; j < 8; j++) send(16'h0000);
    check("E_busy_post", int'(busy), 1);
    do_arm(2'b11, 1'b0, 8'h00, 8'd0, 1'b1);
    check("E_busy_rearm", int'(busy), 1);
    check("E_done_rearm", int'(done), 0);
    n = 0;
    while (!done && n < 40) begin
      send({8'(8'h40 + n), 8'(8'h30 + n)});
      n++;
    end
    check("E_samples", n, 16);
    check("E_trig_addr", int'(trig_addr), 5);
    readout(4, "E");

    // F: reset for two cycles in the middle of POST
    do_arm(2'b11, 1'b0, 8'h00, 8'd0, 1'b0);
    for (int j = 0; j < 8; j++) send(16'h1234);
    check("F_busy_pre_rst", int'(busy), 1);
    sys_rst = 1'b1;
    tick(); tick();
    check("F_busy", int'(busy), 0);
    check("F_done", int'(done), 0);
    check("F_trig_addr", int'(trig_addr), 0);
    check("F_rd_data", int'(rd_data), 0);
    sys_rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
